ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end that succeeds the single-cycle PC/add4/instruction-memory path.
- Owns the fetch PC and issues sequential word fetches to instruction memory over a request/response handshake.
- Buffers fetched instructions with their PCs in a DEPTH-entry FIFO and hands them to decode under valid/ready.
- Branch, jump, jal and jr targets arrive later through a redirect port, which flushes the queue and refetches from the target.

Parameters:
- ADDR_W, 32: PC/address width in bits.
- INST_W, 32: instruction width in bits.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h00400000: fetch PC after reset.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; word aligned.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  INST_W  fetched instruction.
- inst_valid  out  1  queue head is valid.
- inst  out  INST_W  head instruction.
- inst_pc  out  ADDR_W  PC of the head instruction.
- inst_ready  in  1  decode consumes the head when inst_valid is also high.
- redirect  in  1  flush the queue and restart fetch.
- redirect_pc  in  ADDR_W  restart address.
- halt  in  1  stop issuing new requests (syscall exit); the queue still drains.
- err_misalign  out  1  one-cycle pulse: redirect_pc[1:0] was nonzero.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - fetch_pc=RESET_PC, count=0, read/write pointers=0, FSM=IDLE.
  - inst_valid=0, err_misalign=0, imem_req=0, inst=0, inst_pc=0.
- At most one request is outstanding.
- FSM states:
  - IDLE: nothing outstanding.
  - WAIT: response pending; it will be enqueued.
  - KILL: response pending; it will be discarded.
- imem_req is combinational: high when FSM==IDLE and !halt and !redirect and count<DEPTH. imem_addr=fetch_pc.
- Request accepted (imem_req & imem_gnt): go to WAIT; fetch_pc += 4, wrapping modulo 2^ADDR_W.
- WAIT + imem_rvalid without redirect: enqueue {imem_rdata, pc_of_request}, go to IDLE. A new request may issue the following cycle, not the same cycle.
- Space rule: count<DEPTH is checked at issue, and nothing else enqueues while WAIT. The response slot is therefore guaranteed, so the FIFO can never overflow.
- Dequeue when inst_valid & inst_ready. Enqueue and dequeue in the same cycle leave count unchanged. inst/inst_pc show the head combinationally from the array.
- Latency: an empty queue in IDLE with a 1-cycle memory gives grant at t, rvalid at t+1, inst_valid at t+2.
- redirect=1 in cycle t (highest priority):
  - At t+1: count=0 and pointers reset.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Any dequeue or enqueue in cycle t is ignored.
  - FSM: WAIT->KILL if the response has not arrived by t; IDLE stays IDLE; KILL stays KILL.
  - A response with imem_rvalid in the same cycle t is dropped.
  - err_misalign pulses at t+1 if redirect_pc[1:0]!=0.
- KILL + imem_rvalid: drop the data, go to IDLE. A redirect in the same cycle keeps the new target, and the FSM still goes to IDLE.
- Back-to-back redirects: the last one wins; each flushes.
- halt: masks only new requests. An outstanding response still completes, and redirect is still honoured.
- Reset mid-transaction: all state is cleared. Any response arriving after reset release with FSM==IDLE is ignored, since rvalid in IDLE is discarded.
- count width is $clog2(DEPTH+1); pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package/header (mips.h extension): FETCH_IDLE/FETCH_WAIT/FETCH_KILL state encodings, RESET_PC default, word-align macro.
- One sub-module is natural: fetch_fifo, a parametrised synchronous FIFO (DEPTH, INST_W+ADDR_W) with enq, deq, clear, count, and asynchronous active-low reset. The FSM and PC logic stay in ifetch_queue.

Test Plan:
- Reset release, memory granting every cycle with 1-cycle latency, inst_ready=1 -> imem_addr sequence 00400000, 00400004, 00400008 on alternate cycles; inst_pc follows in order; first inst_valid 2 cycles after first grant.
- inst_ready=0, DEPTH=4 -> exactly 4 grants; count=4; imem_req stays 0. Raise inst_ready -> entries drain with PCs 00400000..0040000C, then fetch resumes at 00400010.
- Redirect to 00400100 while a request is outstanding (rvalid 3 cycles later) -> stale rdata is not enqueued; queue empties the next cycle; next imem_addr=00400100; first delivered inst_pc=00400100.
- Redirect and imem_rvalid in the same cycle, plus simultaneous inst_ready -> response dropped, no dequeue counted, count=0 the next cycle.
- redirect_pc=00400102 -> err_misalign high exactly one cycle; next imem_addr=00400100.
- fetch_pc=FFFFFFFC, grant -> next imem_addr=00000000. Assert halt with 2 queued -> no new req, both drain, inst_valid=0 afterwards. Assert reset_n=0 mid-WAIT -> all outputs return to reset values immediately, independent of clock.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-path definitions: fetch FSM encodings, default reset PC and
// the word-alignment helper used on redirect targets.
package ifetch_queue_pkg;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_KILL = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Instruction addresses carry no byte offset; any set low bit is an error.
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return |lowBits;
  endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} entries; the head is
// visible combinationally and clear empties it in one cycle.
module ifetch_queue_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enqData,
  input  logic             deq,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doEnq;
  logic             doDeq;

  assign empty    = (count == '0);
  assign doDeq    = deq & ~empty;
  assign doEnq    = enq & ((count != CNT_W'(DEPTH)) | doDeq);
  assign headData = mem[rdPtr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doEnq) begin
        mem[wrPtr] <= enqData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doDeq) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({doEnq, doDeq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one memory request in
// flight, buffers responses for decode and restarts on redirect.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              err_misalign
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = INST_W + ADDR_W;

  logic [1:0]         stateQ;
  logic [1:0]         stateD;
  logic [ADDR_W-1:0]  fetchPcQ;
  logic [ADDR_W-1:0]  fetchPcD;
  logic [ADDR_W-1:0]  reqPcQ;
  logic               errMisalignQ;
  logic               reqFire;
  logic               rspAccept;
  logic               popHead;
  logic               fifoEmpty;
  logic [CNT_W-1:0]   fifoCount;
  logic [ENTRY_W-1:0] headData;

  // Space is reserved at issue time, so an accepted response always fits.
  assign imem_req = reset_n & (stateQ == FETCH_IDLE) & ~halt & ~redirect &
                    (fifoCount < CNT_W'(DEPTH));
  assign imem_addr    = fetchPcQ;
  assign reqFire      = imem_req & imem_gnt;
  assign rspAccept    = (stateQ == FETCH_WAIT) & imem_rvalid & ~redirect;
  assign popHead      = ~fifoEmpty & inst_ready & ~redirect;
  assign inst_valid   = ~fifoEmpty;
  assign {inst, inst_pc} = headData;
  assign err_misalign = errMisalignQ;

  ifetch_queue_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .enq      (rspAccept),
    .enqData  ({imem_rdata, reqPcQ}),
    .deq      (popHead),
    .clear    (redirect),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .headData (headData)
  );

  // A redirect turns a still-pending response into one that must be dropped.
  always_comb begin
    stateD = stateQ;
    if (redirect) begin
      case (stateQ)
        FETCH_WAIT: stateD = imem_rvalid ? FETCH_IDLE : FETCH_KILL;
        FETCH_KILL: stateD = imem_rvalid ? FETCH_IDLE : FETCH_KILL;
        default:    stateD = FETCH_IDLE;
      endcase
    end else begin
      case (stateQ)
        FETCH_IDLE: if (reqFire) stateD = FETCH_WAIT;
        FETCH_WAIT: if (imem_rvalid) stateD = FETCH_IDLE;
        FETCH_KILL: if (imem_rvalid) stateD = FETCH_IDLE;
        default:    stateD = FETCH_IDLE;
      endcase
    end
  end

  always_comb begin
    fetchPcD = fetchPcQ;
    if (redirect) begin
      fetchPcD = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (reqFire) begin
      fetchPcD = fetchPcQ + ADDR_W'(4);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ       <= FETCH_IDLE;
      fetchPcQ     <= RESET_PC;
      reqPcQ       <= '0;
      errMisalignQ <= 1'b0;
    end else begin
      stateQ       <= stateD;
      fetchPcQ     <= fetchPcD;
      errMisalignQ <= redirect & isMisaligned(redirect_pc[1:0]);
      if (reqFire) begin
        reqPcQ <= fetchPcQ;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized
// traffic checked against a queue-based model of the fetch stream.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        err_misalign;

  ifetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .err_misalign (err_misalign)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Staged stimulus, applied at the next falling edge by tick().
  logic        sRedirect = 1'b0;
  logic [31:0] sRedirectPc = '0;
  logic        sHalt = 1'b0;
  logic        sReady = 1'b0;
  logic        sGnt = 1'b0;
  int          sLat = 1;

  // Memory model and reference model of the delivered instruction stream.
  logic        pendValid = 1'b0;
  logic        pendCounts = 1'b0;
  logic [31:0] pendAddr = '0;
  int          pendDelay = 0;
  int          pendEpoch = 0;
  int          epoch = 0;
  logic [31:0] q[$];
  logic [31:0] expFetch = RESET_PC;
  logic        errPending = 1'b0;

  // Observed values and model expectations of the last tick.
  logic        oReq, oValid, oErr, oGrant, oDeliver;
  logic [31:0] oAddr, oInst, oPc;
  logic        eReq, eValid, eErr;
  logic [31:0] eAddr, eInst, ePc;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic tick();
    logic        rv;
    logic        live;
    logic        outst;
    logic [31:0] rdAddr;
    @(negedge clock);
    redirect    = sRedirect;
    redirect_pc = sRedirectPc;
    halt        = sHalt;
    inst_ready  = sReady;
    outst  = pendValid && pendCounts;
    rv     = 1'b0;
    rdAddr = pendAddr;
    if (pendValid) begin
      pendDelay--;
      if (pendDelay <= 0) begin
        rv        = 1'b1;
        pendValid = 1'b0;
      end
    end
    live        = rv && pendCounts && (pendEpoch == epoch);
    imem_rvalid = rv;
    imem_rdata  = rv ? memData(rdAddr) : $urandom;
    imem_gnt    = sGnt;
    #1;
    eReq   = !outst && !sHalt && !sRedirect && (q.size() < DEPTH);
    eValid = (q.size() != 0);
    ePc    = eValid ? q[0] : 32'h0;
    eInst  = memData(ePc);
    eErr   = errPending;
    eAddr  = expFetch;
    oReq     = imem_req;
    oAddr    = imem_addr;
    oValid   = inst_valid;
    oInst    = inst;
    oPc      = inst_pc;
    oErr     = err_misalign;
    oGrant   = imem_req && imem_gnt;
    oDeliver = inst_valid && inst_ready && !redirect;
    if (sRedirect) begin
      q.delete();
      expFetch   = {sRedirectPc[31:2], 2'b00};
      errPending = (sRedirectPc[1:0] != 2'b00);
      epoch++;
    end else begin
      errPending = 1'b0;
      if (live) q.push_back(rdAddr);
      if (oDeliver && q.size() != 0) void'(q.pop_front());
      if (oGrant) begin
        pendValid  = 1'b1;
        pendCounts = 1'b1;
        pendAddr   = expFetch;
        pendDelay  = sLat;
        pendEpoch  = epoch;
        expFetch   = expFetch + 32'd4;
      end
    end
    @(posedge clock);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (inst_valid !== 1'b0) begin errors++;
      $display("FAIL reset_inst_valid got %0b want 0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL reset_imem_req got %0b want 0", imem_req); end
    checks++; if (err_misalign !== 1'b0) begin errors++;
      $display("FAIL reset_err got %0b want 0", err_misalign); end
    checks++; if (inst !== 32'h0) begin errors++;
      $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++;
      $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    int          gCyc[$];
    logic [31:0] gAddr[$];
    int          firstValid = -1;
    logic [31:0] nextPc = RESET_PC;
    sReady = 1'b1; sGnt = 1'b1; sLat = 1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (oGrant) begin gCyc.push_back(c); gAddr.push_back(oAddr); end
      if (oValid && firstValid < 0) firstValid = c;
      if (oDeliver) begin
        checks++; if (oPc !== nextPc || oInst !== memData(nextPc)) begin errors++;
          $display("FAIL stream_deliver got pc %h inst %h want pc %h inst %h",
                   oPc, oInst, nextPc, memData(nextPc)); end
        nextPc = nextPc + 32'd4;
      end
    end
    checks++; if (gCyc.size() < 3) begin errors++;
      $display("FAIL stream_grants got %0d want >=3", gCyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gAddr[i] !== RESET_PC + 32'(4 * i) || gCyc[i] !== gCyc[0] + 2 * i) begin
          errors++;
          $display("FAIL stream_grant%0d got addr %h cyc %0d want addr %h cyc %0d", i,
                   gAddr[i], gCyc[i], RESET_PC + 32'(4 * i), gCyc[0] + 2 * i);
        end
      end
      checks++; if (firstValid !== gCyc[0] + 2) begin errors++;
        $display("FAIL stream_latency got %0d want %0d", firstValid, gCyc[0] + 2); end
    end
  endtask

  task automatic test_fill();
    int          grants = 0;
    int          delivered = 0;
    logic [31:0] firstGrant = 32'hDEAD_BEEF;
    logic        gotGrant = 1'b0;
    sReady = 1'b0; sGnt = 1'b1; sLat = 1;
    sRedirect = 1'b1; sRedirectPc = RESET_PC;
    tick();
    sRedirect = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (oGrant) grants++;
    end
    checks++; if (grants !== DEPTH) begin errors++;
      $display("FAIL fill_grants got %0d want %0d", grants, DEPTH); end
    checks++; if (oReq !== 1'b0 || oValid !== 1'b1 || oPc !== RESET_PC) begin errors++;
      $display("FAIL fill_full got req %0b valid %0b pc %h want 0 1 %h",
               oReq, oValid, oPc, RESET_PC); end
    sReady = 1'b1;
    for (int c = 0; c < 30 && !(delivered >= DEPTH && gotGrant); c++) begin
      tick();
      if (oGrant && !gotGrant) begin gotGrant = 1'b1; firstGrant = oAddr; end
      if (oDeliver && delivered < DEPTH) begin
        checks++; if (oPc !== RESET_PC + 32'(4 * delivered)) begin errors++;
          $display("FAIL fill_drain got %h want %h", oPc, RESET_PC + 32'(4 * delivered));
        end
        delivered++;
      end
    end
    checks++; if (firstGrant !== 32'h0040_0010) begin errors++;
      $display("FAIL fill_resume got %h want 00400010", firstGrant); end
  endtask

  task automatic test_redirect_outstanding();
    logic got;
    sRedirect = 1'b1; sRedirectPc = 32'h0040_0200; sGnt = 1'b0; sReady = 1'b1;
    tick();
    sRedirect = 1'b0;
    for (int c = 0; c < 10 && pendValid; c++) tick();
    sGnt = 1'b1; sLat = 3; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin tick(); got = oGrant; end
    checks++; if (!got) begin errors++; $display("FAIL redir_prep got 0 want 1"); end
    sGnt = 1'b0; sRedirect = 1'b1; sRedirectPc = 32'h0040_0100;
    tick();
    sRedirect = 1'b0; sGnt = 1'b1; sLat = 1;
    tick();
    checks++; if (oValid !== 1'b0) begin errors++;
      $display("FAIL redir_flush got %0b want 0", oValid); end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (oGrant) begin
        got = 1'b1;
        checks++; if (oAddr !== 32'h0040_0100) begin errors++;
          $display("FAIL redir_addr got %h want 00400100", oAddr); end
      end
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (oDeliver) begin
        got = 1'b1;
        checks++; if (oPc !== 32'h0040_0100 || oInst !== memData(32'h0040_0100)) begin
          errors++; $display("FAIL redir_first got pc %h inst %h want 00400100 %h",
                             oPc, oInst, memData(32'h0040_0100)); end
      end
    end
    checks++; if (!got) begin errors++; $display("FAIL redir_deliver got 0 want 1"); end
  endtask

  task automatic test_same_cycle();
    logic got = 1'b0;
    sRedirect = 1'b1; sRedirectPc = 32'h0040_0300; sReady = 1'b0; sGnt = 1'b1; sLat = 2;
    tick();
    sRedirect = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = (q.size() >= 1) && pendValid && (pendDelay == 1);
    end
    checks++; if (!got) begin errors++; $display("FAIL same_prep got 0 want 1"); end
    sRedirect = 1'b1; sRedirectPc = 32'h0040_0400; sReady = 1'b1; sGnt = 1'b0;
    tick();
    checks++; if (oValid !== 1'b1 || imem_rvalid !== 1'b1) begin errors++;
      $display("FAIL same_setup got valid %0b rvalid %0b want 1 1", oValid, imem_rvalid); end
    sRedirect = 1'b0;
    tick();
    checks++; if (oValid !== 1'b0 || oReq !== 1'b1 || oAddr !== 32'h0040_0400) begin
      errors++; $display("FAIL same_drop got valid %0b req %0b addr %h want 0 1 00400400",
                         oValid, oReq, oAddr); end
  endtask

  task automatic test_misalign();
    logic got = 1'b0;
    sGnt = 1'b0; sReady = 1'b1;
    sRedirect = 1'b1; sRedirectPc = 32'h0040_0102;
    tick();
    checks++; if (oErr !== 1'b0) begin errors++;
      $display("FAIL misalign_early got %0b want 0", oErr); end
    sRedirect = 1'b0;
    tick();
    checks++; if (oErr !== 1'b1) begin errors++;
      $display("FAIL misalign_pulse got %0b want 1", oErr); end
    sGnt = 1'b1; sLat = 1;
    tick();
    checks++; if (oErr !== 1'b0) begin errors++;
      $display("FAIL misalign_width got %0b want 0", oErr); end
    got = oGrant;
    checks++; if (!got || oAddr !== 32'h0040_0100) begin errors++;
      $display("FAIL misalign_addr got grant %0b addr %h want 1 00400100", got, oAddr); end
  endtask

  task automatic test_wrap();
    int          n = 0;
    logic [31:0] addrs[2];
    sGnt = 1'b0; sReady = 1'b1;
    for (int c = 0; c < 10 && pendValid; c++) tick();
    sRedirect = 1'b1; sRedirectPc = 32'hFFFF_FFFC;
    tick();
    sRedirect = 1'b0; sGnt = 1'b1; sLat = 1;
    for (int c = 0; c < 20 && n < 2; c++) begin
      tick();
      if (oGrant) begin addrs[n] = oAddr; n++; end
    end
    checks++; if (n !== 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      errors++; $display("FAIL wrap got n %0d addrs %h %h want 2 fffffffc 00000000",
                         n, addrs[0], addrs[1]); end
  endtask

  task automatic test_halt();
    int delivered = 0;
    sRedirect = 1'b1; sRedirectPc = 32'h0040_0500; sReady = 1'b0; sGnt = 1'b1; sLat = 1;
    tick();
    sRedirect = 1'b0;
    for (int c = 0; c < 20 && q.size() < 2; c++) tick();
    sHalt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (oReq !== 1'b0 || oValid !== 1'b1) begin errors++;
        $display("FAIL halt_hold got req %0b valid %0b want 0 1", oReq, oValid); end
    end
    sReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (oDeliver) begin
        checks++; if (oPc !== 32'h0040_0500 + 32'(4 * delivered)) begin errors++;
          $display("FAIL halt_drain got %h want %h", oPc, 32'h0040_0500 + 32'(4 * delivered));
        end
        delivered++;
      end
    end
    checks++; if (delivered !== 2 || oValid !== 1'b0 || oReq !== 1'b0) begin errors++;
      $display("FAIL halt_end got n %0d valid %0b req %0b want 2 0 0",
               delivered, oValid, oReq); end
    sHalt = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    sReady = 1'b0; sGnt = 1'b1; sLat = 3;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      got = (q.size() >= 1) && pendValid;
    end
    checks++; if (!got) begin errors++; $display("FAIL rstmid_prep got 0 want 1"); end
    sGnt = 1'b0;
    @(negedge clock);
    #2;
    checks++; if (inst_valid !== 1'b1) begin errors++;
      $display("FAIL rstmid_before got %0b want 1", inst_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || err_misalign !== 1'b0 ||
                  inst !== 32'h0 || inst_pc !== 32'h0) begin errors++;
      $display("FAIL rstmid_async got valid %0b req %0b err %0b inst %h pc %h want zeros",
               inst_valid, imem_req, err_misalign, inst, inst_pc); end
    q.delete(); expFetch = RESET_PC; errPending = 1'b0; pendCounts = 1'b0; epoch++;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    sReady = 1'b1;
    for (int c = 0; c < 10 && pendValid; c++) tick();
    tick();
    checks++; if (oValid !== 1'b0 || oReq !== 1'b1 || oAddr !== RESET_PC) begin errors++;
      $display("FAIL rstmid_after got valid %0b req %0b addr %h want 0 1 %h",
               oValid, oReq, oAddr, RESET_PC); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      sReady    = ($urandom % 4) != 0;
      sGnt      = ($urandom % 3) != 0;
      sLat      = $urandom_range(1, 3);
      sHalt     = ($urandom % 16) == 0;
      sRedirect = ($urandom % 20) == 0;
      sRedirectPc = 32'h0040_0000 + 32'($urandom_range(0, 255) << 2) +
                    32'((($urandom % 4) == 0) ? ($urandom % 4) : 0);
      tick();
      checks++; if (oReq !== eReq) begin errors++;
        $display("FAIL rand_req cyc %0d got %0b want %0b", c, oReq, eReq); end
      checks++; if (oValid !== eValid) begin errors++;
        $display("FAIL rand_valid cyc %0d got %0b want %0b", c, oValid, eValid); end
      checks++; if (oErr !== eErr) begin errors++;
        $display("FAIL rand_err cyc %0d got %0b want %0b", c, oErr, eErr); end
      if (eValid) begin
        checks++; if (oPc !== ePc || oInst !== eInst) begin errors++;
          $display("FAIL rand_head cyc %0d got %h %h want %h %h", c, oPc, oInst, ePc, eInst);
        end
      end
      if (eReq) begin
        checks++; if (oAddr !== eAddr) begin errors++;
          $display("FAIL rand_addr cyc %0d got %h want %h", c, oAddr, eAddr); end
      end
    end
    sRedirect = 1'b0; sHalt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_outstanding();
    test_same_cycle();
    test_misalign();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
